// File: rtl/pixsched_pkg.sv
// pixsched_pkg: shared state encoding and coordinate constants for the pixel layer scheduler
package pixsched_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int COORD_W   = 11;
    localparam int X_MAX_DEF = 1920;
    localparam int Y_MAX_DEF = 1080;
endpackage

// File: rtl/next_layer_sel.sv
// next_layer_sel: priority search over a layer mask for first, next-after-current and is-last
module next_layer_sel #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] cur_i,
    output logic [W-1:0] first_o,
    output logic [W-1:0] next_o,
    output logic         is_last_o
);
    // Downward scans so the lowest qualifying bit wins.
    always_comb begin
        first_o   = '0;
        next_o    = '0;
        is_last_o = 1'b1;
        for (int i = N - 1; i >= 0; i--)
            if (mask_i[i]) first_o = W'(i);
        for (int i = N - 1; i >= 0; i--)
            if (mask_i[i] && i > int'(cur_i)) begin
                next_o    = W'(i);
                is_last_o = 1'b0;
            end
    end
endmodule

// File: rtl/pixel_layer_scheduler.sv
// pixel_layer_scheduler: valid/ready-paced per-pixel layer walk over one frame (option: PIXSCHED_LAYER_SKIP_EN)
module pixel_layer_scheduler
    import pixsched_pkg::*;
#(
    parameter int X_MAX      = X_MAX_DEF,
    parameter int Y_MAX      = Y_MAX_DEF,
    parameter int NUM_LAYERS = 4,
    parameter int LAYER_W    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [NUM_LAYERS-1:0] layer_en_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [COORD_W-1:0]    x_o,
    output logic [COORD_W-1:0]    y_o,
    output logic [LAYER_W-1:0]    layer_o,
    output logic                  last_layer_o,
    output logic                  end_of_line_o,
    output logic                  end_of_frame_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_MAX - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_MAX - 1);

    state_t               state_q;
    logic [COORD_W-1:0]   x_q, y_q;
    logic [LAYER_W-1:0]   layer_q;
    logic                 valid_q, done_q;
    logic [NUM_LAYERS-1:0] mask;
    logic [LAYER_W-1:0]   first_l, next_l;
    logic                 is_last;

`ifdef PIXSCHED_LAYER_SKIP_EN
    logic [NUM_LAYERS-1:0] mask_q;
    // In IDLE the live enables pick the first layer; the frame then uses the captured copy.
    assign mask = (state_q == IDLE) ? layer_en_i : mask_q;
`else
    logic unused_en;
    assign unused_en = ^layer_en_i;
    assign mask      = '1;
`endif

    next_layer_sel #(.N(NUM_LAYERS), .W(LAYER_W)) u_sel (
        .mask_i   (mask),
        .cur_i    (layer_q),
        .first_o  (first_l),
        .next_o   (next_l),
        .is_last_o(is_last)
    );

    // Frame sequencer: owns state, coordinates, layer index and the registered valid/done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            layer_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef PIXSCHED_LAYER_SKIP_EN
            mask_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
`ifdef PIXSCHED_LAYER_SKIP_EN
                    mask_q <= layer_en_i;
                    if (layer_en_i == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else
`endif
                    begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                        layer_q <= first_l;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                RUN: if (abort_i) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    x_q     <= '0;
                    y_q     <= '0;
                    layer_q <= '0;
                end else if (out_ready_i) begin
                    if (!is_last) begin
                        layer_q <= next_l;
                    end else if (x_q < X_LAST) begin
                        x_q     <= x_q + COORD_W'(1);
                        layer_q <= first_l;
                    end else if (y_q < Y_LAST) begin
                        x_q     <= '0;
                        y_q     <= y_q + COORD_W'(1);
                        layer_q <= first_l;
                    end else begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        x_q     <= '0;
                        y_q     <= '0;
                        layer_q <= '0;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid_o    = valid_q;
    assign x_o            = x_q;
    assign y_o            = y_q;
    assign layer_o        = layer_q;
    assign last_layer_o   = valid_q && is_last;
    assign end_of_line_o  = last_layer_o && (x_q == X_LAST);
    assign end_of_frame_o = end_of_line_o && (y_q == Y_LAST);
    assign busy_o         = (state_q == RUN);
    assign done_o         = done_q;
endmodule

// File: tb/tb_pixel_layer_scheduler.sv
// tb_pixel_layer_scheduler: directed table-driven bench for the pixel layer scheduler
module tb_pixel_layer_scheduler;
    localparam int X_MAX   = 4;
    localparam int Y_MAX   = 2;
    localparam int LAYER_W = 2;
`ifdef PIXSCHED_LAYER_SKIP_EN
    localparam int NUM_LAYERS = 4;
    localparam logic [NUM_LAYERS-1:0] EN = 4'b1010;
`else
    localparam int NUM_LAYERS = 2;
    localparam logic [NUM_LAYERS-1:0] EN = 2'b11;
`endif

    typedef struct {
        logic        rdy;
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  layer;
        logic        last;
        logic        eol;
        logic        eof;
    } beat_t;

    logic clk = 1'b0;
    logic reset, start, abort, out_ready;
    logic [NUM_LAYERS-1:0] layer_en;
    logic out_valid, last_layer, end_of_line, end_of_frame, busy, done;
    logic [10:0] x, y;
    logic [LAYER_W-1:0] layer;

    beat_t tbl[64];
    int n_beats = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pixel_layer_scheduler #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .NUM_LAYERS(NUM_LAYERS), .LAYER_W(LAYER_W)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start), .abort_i(abort),
        .layer_en_i(layer_en), .out_ready_i(out_ready), .out_valid_o(out_valid),
        .x_o(x), .y_o(y), .layer_o(layer), .last_layer_o(last_layer),
        .end_of_line_o(end_of_line), .end_of_frame_o(end_of_frame),
        .busy_o(busy), .done_o(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int i);
        chk($sformatf("%s[%0d].valid", tag, i), {31'd0, out_valid}, 1);
        chk($sformatf("%s[%0d].x", tag, i), {21'd0, x}, {21'd0, tbl[i].x});
        chk($sformatf("%s[%0d].y", tag, i), {21'd0, y}, {21'd0, tbl[i].y});
        chk($sformatf("%s[%0d].layer", tag, i), 32'(layer), {30'd0, tbl[i].layer});
        chk($sformatf("%s[%0d].last", tag, i), {31'd0, last_layer}, {31'd0, tbl[i].last});
        chk($sformatf("%s[%0d].eol", tag, i), {31'd0, end_of_line}, {31'd0, tbl[i].eol});
        chk($sformatf("%s[%0d].eof", tag, i), {31'd0, end_of_frame}, {31'd0, tbl[i].eof});
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, ".valid"}, {31'd0, out_valid}, 0);
        chk({tag, ".busy"}, {31'd0, busy}, 0);
        chk({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, ".eof"}, {31'd0, end_of_frame}, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int hi;
        int idx;
        int cyc;
        logic [NUM_LAYERS-1:0] en_v;
        en_v = EN;
        hi = 0;
        for (int l = 0; l < NUM_LAYERS; l++) if (en_v[l]) hi = l;
        for (int yy = 0; yy < Y_MAX; yy++)
            for (int xx = 0; xx < X_MAX; xx++)
                for (int l = 0; l < NUM_LAYERS; l++)
                    if (en_v[l]) begin
                        tbl[n_beats].rdy   = 1'b1;
                        tbl[n_beats].x     = 11'(xx);
                        tbl[n_beats].y     = 11'(yy);
                        tbl[n_beats].layer = 2'(l);
                        tbl[n_beats].last  = (l == hi);
                        tbl[n_beats].eol   = (l == hi) && (xx == X_MAX - 1);
                        tbl[n_beats].eof   = (l == hi) && (xx == X_MAX - 1) && (yy == Y_MAX - 1);
                        n_beats++;
                    end

        reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; layer_en = EN;
        tick(); tick();
        chk_idle("reset", 1'b0);
        chk("reset.x", {21'd0, x}, 0);
        chk("reset.y", {21'd0, y}, 0);
        chk("reset.layer", 32'(layer), 0);
        reset = 1'b1;
        tick();
        chk_idle("idle", 1'b0);
        chk("beats_per_frame", n_beats, 16);

        // Basic frame, with a stray start while busy.
        do_start();
        for (int i = 0; i < n_beats; i++) begin
            chk_beat("basic", i);
            chk("basic.busy", {31'd0, busy}, 1);
            out_ready = tbl[i].rdy;
            start = (i == 3);
            tick();
        end
        start = 1'b0;
        chk_idle("basic_done", 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_idle("after_done", 1'b0);
        tick();
        chk_idle("start_in_done_ignored", 1'b0);

        // Backpressure.
        do_start();
        idx = 0;
        cyc = 0;
        while (idx < n_beats && cyc < 400) begin
            chk_beat("bp", idx);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (out_ready) idx++;
        end
        if (idx < n_beats) chk("bp_timeout", 0, 1);
        chk_idle("bp_done", 1'b1);
        out_ready = 1'b1;
        tick();

        // Abort on beat 7 together with a transfer.
        do_start();
        for (int i = 0; i < 6; i++) begin
            chk_beat("abort_pre", i);
            tick();
        end
        chk_beat("abort_pre", 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort", 1'b0);
        chk("abort.x", {21'd0, x}, 0);
        chk("abort.layer", 32'(layer), 0);
        tick();
        chk_idle("abort_nodone", 1'b0);
        do_start();
        for (int i = 0; i < n_beats; i++) begin
            chk_beat("restart", i);
            tick();
        end
        chk_idle("restart_done", 1'b1);
        tick();

        // Reset on beat 5 with a simultaneous start.
        do_start();
        for (int i = 0; i < 4; i++) begin
            chk_beat("rst_pre", i);
            tick();
        end
        chk_beat("rst_pre", 4);
        reset = 1'b0;
        start = 1'b1;
        tick();
        reset = 1'b1;
        start = 1'b0;
        chk_idle("midreset", 1'b0);
        chk("midreset.x", {21'd0, x}, 0);
        chk("midreset.layer", 32'(layer), 0);
        tick();
        chk_idle("midreset_start_ignored", 1'b0);

`ifdef PIXSCHED_LAYER_SKIP_EN
        layer_en = '0;
        do_start();
        chk_idle("empty_mask", 1'b1);
        tick();
        chk_idle("empty_mask_after", 1'b0);
        layer_en = EN;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
